column_reducer: RTL and testbench



---
 rtl/column_reducer_pkg.sv | 8 +
 rtl/column_reducer_adder.sv | 80 ++++++++
 rtl/column_reducer.sv | 107 ++++++++++
 tb/tb_column_reducer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/column_reducer_pkg.sv
// column_reducer_pkg: state encodings and float constants shared by the reducer, its adder and benches.
package column_reducer_pkg;
  localparam int FLOAT_WIDTH = 32;
  localparam logic [31:0] FP_ZERO = 32'h00000000;
  localparam logic [31:0] FP_ONE = 32'h3F800000;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADD, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {A_GET_A, A_GET_B, A_CALC, A_PUT_Z} adder_state_t;
endpackage

// File: rtl/column_reducer_adder.sv
// single_adder: IEEE-754 single-precision adder (round-to-nearest-even) behind a stb/ack handshake.
module single_adder
  import column_reducer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  adder_state_t st;
  logic [31:0] a, b, xv, yv, sum;
  logic swap, rnd, a_nan, b_nan, a_inf, b_inf;
  logic [7:0] ex, ey;
  logic [23:0] mx, my;
  logic [8:0] d;
  logic [49:0] yw;
  logic [26:0] ys, m;
  logic [27:0] s;
  logic [4:0] lz, sh;
  logic [9:0] e;
  logic [30:0] mag;
  assign input_a_ack = st == A_GET_A;
  assign input_b_ack = st == A_GET_B;
  assign output_z_stb = st == A_PUT_Z;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= A_GET_A;
      a <= '0;
      b <= '0;
      output_z <= '0;
    end else begin
      unique case (st)
        A_GET_A: if (input_a_stb) begin a <= input_a; st <= A_GET_B; end
        A_GET_B: if (input_b_stb) begin b <= input_b; st <= A_CALC; end
        A_CALC:  begin output_z <= sum; st <= A_PUT_Z; end
        A_PUT_Z: if (output_z_ack) st <= A_GET_A;
        default: st <= A_GET_A;
      endcase
    end
  end
  // x is the larger magnitude; y is aligned into 24 mantissa bits plus guard, round and sticky
  always_comb begin
    swap = b[30:0] > a[30:0];
    xv = swap ? b : a;
    yv = swap ? a : b;
    ex = (xv[30:23] == 8'd0) ? 8'd1 : xv[30:23];
    ey = (yv[30:23] == 8'd0) ? 8'd1 : yv[30:23];
    mx = {|xv[30:23], xv[22:0]};
    my = {|yv[30:23], yv[22:0]};
    d = {1'b0, ex} - {1'b0, ey};
    yw = {my, 26'd0} >> ((d > 9'd26) ? 5'd26 : d[4:0]);
    ys = {yw[49:24], |yw[23:0]};
    s = (xv[31] == yv[31]) ? {1'b0, mx, 3'd0} + {1'b0, ys} : {1'b0, mx, 3'd0} - {1'b0, ys};
    lz = '0;
    for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
    sh = ({3'd0, lz} < ex - 8'd1) ? lz : 5'(ex - 8'd1);
    m = s[27] ? {s[27:2], |s[1:0]} : s[26:0] << sh;
    e = s[27] ? {2'd0, ex} + 10'd1 : {2'd0, ex} - {5'd0, sh};
    rnd = m[2] & (m[3] | m[1] | m[0]);
    // a rounding carry out of the mantissa bumps the exponent field, including denormal to normal
    mag = {m[26] ? e[7:0] : 8'd0, m[25:3]} + {30'd0, rnd};
    sum = {xv[31], mag};
    if (e >= 10'd255) sum = {xv[31], 8'hFF, 23'd0};
    if (s == 28'd0) sum = {xv[31] & yv[31], 31'd0};
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);
    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]))) sum = 32'h7FC00000;
    else if (a_inf) sum = a;
    else if (b_inf) sum = b;
  end
endmodule

// File: rtl/column_reducer.sv
// column_reducer: sums a packed column of floats in index order through one shared single_adder.
// COLUMN_BIAS_EN adds an in_bias port that seeds the accumulator, so size additions are performed.
module column_reducer
  import column_reducer_pkg::*;
#(
  parameter int size = 4,
  parameter int cell_width = FLOAT_WIDTH,
  parameter int width = cell_width * size
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic [width-1:0]      in_c,
`ifdef COLUMN_BIAS_EN
  input  logic [cell_width-1:0] in_bias,
`endif
  input  logic                  in_ready,
  input  logic                  out_ack,
  output logic                  out_ready,
  output logic [cell_width-1:0] out_sum
);
  localparam int CW = $clog2(size + 1);
`ifdef COLUMN_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif
  state_t state, next;
  logic [width-1:0] r_column;
  logic [cell_width-1:0] acc, elem, seed, z;
  logic [CW-1:0] counter, start;
  logic a_seen, b_seen, a_stb, b_stb, a_ack, b_ack, a_done, b_done, z_stb, z_ack, add_rst;
`ifdef COLUMN_BIAS_EN
  logic [cell_width-1:0] r_bias;
  assign seed = r_bias;
  assign start = '0;
`else
  assign seed = r_column[cell_width-1:0];
  assign start = CW'(1);
`endif
  always_comb begin
    elem = r_column[cell_width-1:0];
    for (int i = 0; i < size; i++) if (counter == CW'(i)) elem = r_column[i*cell_width +: cell_width];
    add_rst = state == S_IDLE;
    a_stb = (state == S_ADD) & ~a_seen;
    b_stb = (state == S_ADD) & ~b_seen;
    a_done = a_seen | (a_stb & a_ack);
    b_done = b_seen | (b_stb & b_ack);
    z_ack = (state == S_WAIT) & z_stb;
    unique case (state)
      S_IDLE:  next = in_ready ? S_LOAD : S_IDLE;
      S_LOAD:  next = (!BIAS && size == 1) ? S_DONE : S_ADD;
      S_ADD:   next = (a_done & b_done) ? S_WAIT : S_ADD;
      S_WAIT:  next = z_stb ? ((counter + CW'(1) == CW'(size)) ? S_DONE : S_ADD) : S_WAIT;
      S_DONE:  next = out_ack ? S_IDLE : S_DONE;
      default: next = S_IDLE;
    endcase
  end
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state <= S_IDLE;
      out_ready <= 1'b0;
      out_sum <= '0;
      counter <= '0;
      acc <= '0;
      a_seen <= 1'b0;
      b_seen <= 1'b0;
      r_column <= '0;
`ifdef COLUMN_BIAS_EN
      r_bias <= '0;
`endif
    end else begin
      state <= next;
      // seen flags only survive within ADD, so each new addition re-raises both strobes
      a_seen <= (state == S_ADD) & a_done;
      b_seen <= (state == S_ADD) & b_done;
      out_ready <= state == S_DONE;
      out_sum <= (state == S_DONE) ? acc : '0;
      if (state == S_IDLE && in_ready) begin
        r_column <= in_c;
`ifdef COLUMN_BIAS_EN
        r_bias <= in_bias;
`endif
      end
      if (state == S_LOAD) begin
        acc <= seed;
        counter <= start;
      end
      if (z_ack) begin
        acc <= z;
        counter <= counter + CW'(1);
      end
    end
  end
  single_adder u_adder (
    .clk(in_clk),
    .rst(add_rst),
    .input_a(acc),
    .input_a_stb(a_stb),
    .input_a_ack(a_ack),
    .input_b(elem),
    .input_b_stb(b_stb),
    .input_b_ack(b_ack),
    .output_z(z),
    .output_z_stb(z_stb),
    .output_z_ack(z_ack)
  );
endmodule

// File: tb/tb_column_reducer.sv
// tb_column_reducer: directed vectors for column_reducer (size 4 and size 1), bias path under COLUMN_BIAS_EN.
module tb_column_reducer;
  import column_reducer_pkg::*;
`ifdef COLUMN_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif
  localparam int ZA = BIAS ? 4 : 3;
  localparam int C2 = BIAS ? 1 : 2;
  logic in_clk = 1'b0, in_reset = 1'b0;
  logic [127:0] in_c = '0;
  logic [31:0] in_bias = FP_ZERO, in_c1 = '0, in_bias1 = FP_ZERO;
  logic in_ready = 1'b0, out_ack = 1'b0, in_ready1 = 1'b0, out_ack1 = 1'b0;
  logic out_ready, out_ready1;
  logic [31:0] out_sum, out_sum1;
  int errors = 0, checks = 0, zacks = 0, stb1 = 0;
  typedef struct {
    logic [127:0] c;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];
  always #5 in_clk = ~in_clk;
  column_reducer #(.size(4)) dut (
    .in_clk(in_clk), .in_reset(in_reset), .in_c(in_c),
`ifdef COLUMN_BIAS_EN
    .in_bias(in_bias),
`endif
    .in_ready(in_ready), .out_ack(out_ack), .out_ready(out_ready), .out_sum(out_sum)
  );
  column_reducer #(.size(1)) dut1 (
    .in_clk(in_clk), .in_reset(in_reset), .in_c(in_c1),
`ifdef COLUMN_BIAS_EN
    .in_bias(in_bias1),
`endif
    .in_ready(in_ready1), .out_ack(out_ack1), .out_ready(out_ready1), .out_sum(out_sum1)
  );
  always @(posedge in_clk) begin
    if (dut.z_ack) zacks++;
    if (dut1.a_stb | dut1.b_stb) stb1++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic start(input logic [127:0] c, input logic [31:0] b);
    in_c = c;
    in_bias = b;
    in_ready = 1'b1;
    @(posedge in_clk); #1;
    in_ready = 1'b0;
  endtask
  task automatic wait_ready(input string name);
    int n = 0;
    while (!out_ready && n < 300) begin @(posedge in_clk); #1; n++; end
    chk({name, " timeout"}, 32'(out_ready), 32'd1);
  endtask
  task automatic ack(input string name);
    out_ack = 1'b1;
    @(posedge in_clk); #1;
    out_ack = 1'b0;
    @(posedge in_clk); #1;
    chk({name, " ready drop"}, 32'(out_ready), 32'd0);
  endtask
  initial begin
    int n;
    vecs[0] = '{c: {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, exp: 32'h41200000};
    vecs[1] = '{c: {32'h3F000000, 32'h3F000000, 32'hBF800000, 32'h3F800000}, exp: 32'h3F800000};
    vecs[2] = '{c: {4{FP_ZERO}}, exp: 32'h00000000};
    vecs[3] = '{c: {4{FP_ONE}}, exp: 32'h40800000};
    vecs[4] = '{c: {32'h41000000, 32'hBE800000, 32'h40200000, 32'h3FC00000}, exp: 32'h413C0000};
    vecs[5] = '{c: {32'h33800000, 32'h33800000, 32'h33800000, 32'h3F800000}, exp: 32'h3F800000};
    // 2^24 + 1 + 1 in order: each +1 ties back to 2^24
    vecs[6] = '{c: {FP_ZERO, FP_ONE, FP_ONE, 32'h4B800000}, exp: 32'h4B800000};
    repeat (3) @(posedge in_clk);
    #1;
    chk("reset out_ready", 32'(out_ready), 32'd0);
    chk("reset out_sum", out_sum, 32'd0);
    chk("reset out_ready1", 32'(out_ready1), 32'd0);
    chk("reset out_sum1", out_sum1, 32'd0);
    in_reset = 1'b1;
    @(posedge in_clk); #1;
    for (int i = 0; i < 7; i++) begin
      zacks = 0;
      start(vecs[i].c, FP_ZERO);
      wait_ready($sformatf("vec%0d", i));
      chk($sformatf("vec%0d sum", i), out_sum, vecs[i].exp);
      chk($sformatf("vec%0d adds", i), 32'(zacks), 32'(ZA));
      ack($sformatf("vec%0d", i));
    end
    // size 1: result three cycles after in_ready, adder untouched
    stb1 = 0;
    in_c1 = 32'h40400000;
    in_ready1 = 1'b1;
    @(posedge in_clk); #1;
    in_ready1 = 1'b0;
    n = 1;
    while (!out_ready1 && n < 100) begin @(posedge in_clk); #1; n++; end
    chk("size1 ready", 32'(out_ready1), 32'd1);
    chk("size1 sum", out_sum1, 32'h40400000);
`ifndef COLUMN_BIAS_EN
    chk("size1 latency", 32'(n), 32'd3);
    chk("size1 strobes", 32'(stb1), 32'd0);
`endif
    out_ack1 = 1'b1;
    @(posedge in_clk); #1;
    out_ack1 = 1'b0;
    @(posedge in_clk); #1;
    chk("size1 ready drop", 32'(out_ready1), 32'd0);
    // protocol: in_ready held high, in_c changed after latch, out_ack pulsed during ADD
    in_c = vecs[0].c;
    in_ready = 1'b1;
    @(posedge in_clk); #1;
    in_c = vecs[4].c;
    @(posedge in_clk); #1;
    out_ack = 1'b1;
    @(posedge in_clk); #1;
    out_ack = 1'b0;
    wait_ready("proto");
    chk("proto sum", out_sum, vecs[0].exp);
    repeat (3) @(posedge in_clk);
    #1;
    chk("proto hold ready", 32'(out_ready), 32'd1);
    chk("proto hold sum", out_sum, vecs[0].exp);
    ack("proto");
    wait_ready("proto next");
    chk("proto next sum", out_sum, vecs[4].exp);
    in_ready = 1'b0;
    ack("proto next");
    // asynchronous reset during the WAIT of the second addition
    start(vecs[0].c, FP_ZERO);
    n = 0;
    while (!(dut.state == S_WAIT && dut.counter == C2) && n < 300) begin @(posedge in_clk); #1; n++; end
    chk("rst reached wait", 32'(dut.state), 32'(S_WAIT));
    in_reset = 1'b0;
    #1;
    chk("rst mid out_ready", 32'(out_ready), 32'd0);
    chk("rst mid out_sum", out_sum, 32'd0);
    chk("rst mid state", 32'(dut.state), 32'(S_IDLE));
    repeat (2) @(posedge in_clk);
    #1;
    in_reset = 1'b1;
    @(posedge in_clk); #1;
    start({4{FP_ONE}}, FP_ZERO);
    wait_ready("after rst");
    chk("after rst sum", out_sum, 32'h40800000);
    ack("after rst");
`ifdef COLUMN_BIAS_EN
    zacks = 0;
    start({32'h40800000, 32'h40400000, 32'h40000000, FP_ONE}, 32'h41200000);
    wait_ready("bias");
    chk("bias sum", out_sum, 32'h41A00000);
    chk("bias adds", 32'(zacks), 32'd4);
    ack("bias");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
